// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter in front of one single-port block RAM.
// m0 (CPU fetch/load) and m1 (debug/loader) share the RAM one access per cycle.
// Read data is broadcast to both ports; a tag pipe matched to the RAM read latency
// tells each port when the data on ram_dout is its own. Saturating per-port stall
// counters are kept for debug visibility.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1,   // 1 or 2
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [CNT_W-1:0]  m0_stall_cnt,

    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [CNT_W-1:0]  m1_stall_cnt,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    // Port that won the most recent grant; 1 after reset so m0 wins the first tie.
    logic last_gnt_q, last_gnt_d;

    // Read tag pipe: one {valid, id} entry per cycle of RAM read latency.
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;

    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic any_gnt;

    // Grant decision: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (last_gnt_q) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
        any_gnt = m0_gnt | m1_gnt;
    end

    // RAM request mux; everything idles at zero when nobody is granted.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = '0;
        ram_din  = '0;
        if (m0_gnt) begin
            ram_en   = 1'b1;
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (m1_gnt) begin
            ram_en   = 1'b1;
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Next state for arbitration history, tag pipe and stall counters.
    always_comb begin
        last_gnt_d = any_gnt ? m1_gnt : last_gnt_q;

        // Writes still shift a bubble through so every slot advances each cycle.
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = any_gnt && (ram_we == 4'b0000);
        tag_id_d[0]  = m1_gnt;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (m0_req && !m0_gnt && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (m1_req && !m1_gnt && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // State registers with synchronous reset; reset drops any in-flight read tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    // Read return routing; gated by rst so nothing surfaces during a reset cycle.
    always_comb begin
        m0_rvalid    = !rst && tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
        m1_rvalid    = !rst && tag_vld_q[RD_LAT-1] && tag_id_q[RD_LAT-1];
        m0_rdata     = ram_dout;
        m1_rdata     = ram_dout;
        m0_stall_cnt = cnt0_q;
        m1_stall_cnt = cnt1_q;
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: two arbiter instances (RD_LAT=1/CNT_W=16 and RD_LAT=2/CNT_W=6),
// each with a behavioural RAM, compared every cycle against a transaction-level model.
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req   [2][2];
    logic [3:0]  we    [2][2];
    logic [16:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        gnt   [2][2];
    logic        rvalid[2][2];
    logic [31:0] rdata [2][2];
    logic [15:0] c0_a, c1_a;
    logic [5:0]  c0_b, c1_b;
    int          dcnt  [2][2];

    logic        ram_en   [2];
    logic [3:0]  ram_we   [2];
    logic [16:0] ram_addr [2];
    logic [31:0] ram_din  [2];
    logic [31:0] ram_dout [2];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(input int a);
        return (a == 6) ? 32'h11223344 : (32'hC0DE0000 | 32'(a));
    endfunction

    bram_port_arbiter #(.RD_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
        .m0_stall_cnt(c0_a),
        .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
        .m1_stall_cnt(c1_a),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
    );

    bram_port_arbiter #(.RD_LAT(2), .CNT_W(6)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
        .m0_stall_cnt(c0_b),
        .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
        .m1_stall_cnt(c1_b),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
    );

    always_comb begin
        dcnt[0][0] = int'(c0_a);
        dcnt[0][1] = int'(c1_a);
        dcnt[1][0] = int'(c0_b);
        dcnt[1][1] = int'(c1_b);
    end

    // Behavioural RAMs: instance k has read latency k+1.
    logic [31:0] mem [2][64];
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mem[k][a] = init_word(a);
        end
    end
    for (genvar k = 0; k < 2; k++) begin : g_ram
        always @(posedge clk) begin
            if (ram_en[k]) begin
                if (ram_we[k] != 4'b0000) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_we[k][b]) mem[k][ram_addr[k][5:0]][8*b +: 8] <= ram_din[k][8*b +: 8];
                    end
                end else begin
                    rd1[k] <= mem[k][ram_addr[k][5:0]];
                end
            end
            rd2[k] <= rd1[k];
        end
        assign ram_dout[k] = (k == 0) ? rd1[k] : rd2[k];
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Transaction-level model: expected memory, pending read returns keyed by due cycle.
    int          cyc = 0;
    logic [31:0] mmem  [2][64];
    logic        exp_v [2][4];
    int          exp_p [2][4];
    logic [31:0] exp_d [2][4];
    logic        mlast [2];
    int          mcnt  [2][2];
    int          rv_cnt[2][2];
    logic [31:0] last_rd[2][2];
    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 64; a++) mmem[i][a] = init_word(a);
            for (int s = 0; s < 4; s++) exp_v[i][s] = 1'b0;
            mlast[i] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                mcnt[i][p] = 0;
                rv_cnt[i][p] = 0;
                last_rd[i][p] = '0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        eg [2];
            int          gp, slot, lat, cmax;
            logic        anyg, ev;
            logic [31:0] ed;
            lat  = i + 1;
            cmax = (i == 0) ? 65535 : 63;
            eg[0] = 1'b0;
            eg[1] = 1'b0;
            if (!rst) begin
                if (req[i][0] && req[i][1]) begin
                    eg[0] = mlast[i];
                    eg[1] = !mlast[i];
                end else begin
                    eg[0] = req[i][0];
                    eg[1] = req[i][1];
                end
            end
            anyg = eg[0] | eg[1];
            gp   = eg[1] ? 1 : 0;
            slot = cyc % 4;
            ev   = !rst && exp_v[i][slot];
            ed   = exp_d[i][slot];

            chk("gnt0", i, 64'(gnt[i][0]), 64'(eg[0]));
            chk("gnt1", i, 64'(gnt[i][1]), 64'(eg[1]));
            chk("ram_en", i, 64'(ram_en[i]), 64'(anyg));
            chk("ram_we", i, 64'(ram_we[i]), anyg ? 64'(we[i][gp]) : 64'd0);
            chk("ram_addr", i, 64'(ram_addr[i]), anyg ? 64'(addr[i][gp]) : 64'd0);
            chk("ram_din", i, 64'(ram_din[i]), anyg ? 64'(wdata[i][gp]) : 64'd0);
            chk("rvalid0", i, 64'(rvalid[i][0]), 64'(ev && exp_p[i][slot] == 0));
            chk("rvalid1", i, 64'(rvalid[i][1]), 64'(ev && exp_p[i][slot] == 1));
            if (ev) chk("rdata", i, 64'(rdata[i][exp_p[i][slot]]), 64'(ed));
            chk("stall0", i, 64'(dcnt[i][0]), 64'(mcnt[i][0]));
            chk("stall1", i, 64'(dcnt[i][1]), 64'(mcnt[i][1]));

            for (int p = 0; p < 2; p++) begin
                if (rvalid[i][p]) begin
                    rv_cnt[i][p]++;
                    last_rd[i][p] = rdata[i][p];
                end
            end

            exp_v[i][slot] = 1'b0;
            if (rst) begin
                for (int s = 0; s < 4; s++) exp_v[i][s] = 1'b0;
                mlast[i] = 1'b1;
                mcnt[i][0] = 0;
                mcnt[i][1] = 0;
            end else begin
                if (anyg) begin
                    mlast[i] = eg[1];
                    if (we[i][gp] == 4'b0000) begin
                        exp_v[i][(cyc + lat) % 4] = 1'b1;
                        exp_p[i][(cyc + lat) % 4] = gp;
                        exp_d[i][(cyc + lat) % 4] = mmem[i][addr[i][gp][5:0]];
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (we[i][gp][b]) begin
                                mmem[i][addr[i][gp][5:0]][8*b +: 8] = wdata[i][gp][8*b +: 8];
                            end
                        end
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (req[i][p] && !eg[p] && mcnt[i][p] < cmax) mcnt[i][p]++;
                end
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Single access held until granted, bounded to 20 cycles.
    task automatic access(input int i, input int p, input logic [3:0] w, input int a,
                          input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        req[i][p] = 1'b1;
        we[i][p] = w;
        addr[i][p] = 17'(a);
        wdata[i][p] = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = gnt[i][p];
            tick(1);
        end
        req[i][p] = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout inst%0d port%0d: got no grant expected grant", i, p);
        end
    endtask

    int b0, b1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0;
                we[i][p] = 4'b0000;
                addr[i][p] = '0;
                wdata[i][p] = '0;
            end
        end
        do_reset();
        chk("reset_stall0", 0, 64'(c0_a), 64'd0);
        chk("reset_stall1", 0, 64'(c1_a), 64'd0);

        // Back-to-back m0 reads on the latency-1 instance
        b0 = rv_cnt[0][0];
        b1 = rv_cnt[0][1];
        req[0][0] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr[0][0] = 17'(a);
            tick(1);
        end
        req[0][0] = 1'b0;
        tick(4);
        chk("t1_m0_rvalids", 0, 64'(rv_cnt[0][0] - b0), 64'd4);
        chk("t1_m1_rvalids", 0, 64'(rv_cnt[0][1] - b1), 64'd0);
        chk("t1_last_rdata", 0, 64'(last_rd[0][0]), 64'h00000000C0DE0003);

        // Continuous contention straight after reset
        do_reset();
        req[0][0] = 1'b1;
        addr[0][0] = 17'd10;
        req[0][1] = 1'b1;
        addr[0][1] = 17'd11;
        tick(10);
        chk("t2_stall0", 0, 64'(c0_a), 64'd5);
        chk("t2_stall1", 0, 64'(c1_a), 64'd5);
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        tick(3);

        // Full-word write then read back
        b1 = rv_cnt[0][1];
        access(0, 1, 4'hF, 5, 32'hDEADBEEF);
        access(0, 0, 4'h0, 5, 32'h0);
        tick(3);
        chk("t3_rdata", 0, 64'(last_rd[0][0]), 64'h00000000DEADBEEF);
        chk("t3_no_m1_rvalid", 0, 64'(rv_cnt[0][1] - b1), 64'd0);

        // Byte-lane write merge
        access(0, 1, 4'b0001, 6, 32'h000000AA);
        access(0, 0, 4'h0, 6, 32'h0);
        tick(3);
        chk("t4_rdata", 0, 64'(last_rd[0][0]), 64'h00000000112233AA);

        // Reset with a read in flight
        b0 = rv_cnt[0][0];
        req[0][0] = 1'b1;
        we[0][0] = 4'h0;
        addr[0][0] = 17'd2;
        tick(1);
        req[0][0] = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("t5_no_rvalid", 0, 64'(rv_cnt[0][0] - b0), 64'd0);
        chk("t5_stall0", 0, 64'(c0_a), 64'd0);

        // Latency-2 interleaved reads, then stall saturation
        b0 = rv_cnt[1][0];
        b1 = rv_cnt[1][1];
        req[1][0] = 1'b1;
        addr[1][0] = 17'd8;
        req[1][1] = 1'b1;
        addr[1][1] = 17'd9;
        tick(1);
        req[1][0] = 1'b0;
        tick(1);
        req[1][1] = 1'b0;
        tick(4);
        chk("t6_m0_rvalids", 1, 64'(rv_cnt[1][0] - b0), 64'd1);
        chk("t6_m1_rvalids", 1, 64'(rv_cnt[1][1] - b1), 64'd1);
        chk("t6_m0_rdata", 1, 64'(last_rd[1][0]), 64'h00000000C0DE0008);
        chk("t6_m1_rdata", 1, 64'(last_rd[1][1]), 64'h00000000C0DE0009);
        req[1][0] = 1'b1;
        req[1][1] = 1'b1;
        tick(140);
        chk("t6_sat1", 1, 64'(c1_b), 64'h3F);
        chk("t6_sat0", 1, 64'(c0_b), 64'h3F);
        req[1][0] = 1'b0;
        req[1][1] = 1'b0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
